// File: rtl/decode_pkg.sv
// Shared types for the decode/scan block: operating states and mode encodings.
package decode_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/tick_div.sv
// Scan prescaler: counts 0..div and emits a one-cycle tick on the terminal count.
module tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // ">=" rather than "==" so lowering div below the running count steps at once.
    assign tick = en && !clr && (count >= div);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count >= div) begin
                count <= '0;
            end else begin
                count <= count + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/decode_scan.sv
// One-hot decoder with a DIRECT path from data_in and a SCAN path that walks a single
// active bit up or down at a programmable rate. The current state is exported for debug.
module decode_scan
    import decode_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 load,
    input  logic                 dir,
    input  logic [SEL_W-1:0]     data_in,
    input  logic [DIV_W-1:0]     div,
    output logic [2**SEL_W-1:0]  data_out,
    output logic [SEL_W-1:0]     index_out,
    output logic                 wrap,
    output state_t               state
);

    localparam int               OUT_W    = 2**SEL_W;
    localparam logic [SEL_W-1:0] ONE      = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] LAST     = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] FIRST    = {SEL_W{1'b0}};
    localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_t           state_nxt;
    logic [SEL_W-1:0] index_nxt;
    logic [OUT_W-1:0] data_nxt;
    logic             wrap_nxt;
    logic             clr;
    logic             scan_en;
    logic             tick;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (scan_en),
        .div  (div),
        .tick (tick)
    );

    // State register; index/output registers share it so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            index_out <= '0;
            data_out  <= INACTIVE;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            index_out <= index_nxt;
            data_out  <= data_nxt;
            wrap      <= wrap_nxt;
        end
    end

    // The state is re-derived from en/mode every cycle; no sticky transitions.
    always_comb begin
        state_nxt = IDLE;
        if (!en) begin
            state_nxt = IDLE;
        end else if (mode == MODE_SCAN) begin
            state_nxt = SCAN;
        end else begin
            state_nxt = DIRECT;
        end
    end

    // Actions follow the state being entered this cycle; 'state' is the previous one,
    // which is what identifies an entry into SCAN (prescaler restart, index kept).
    always_comb begin
        index_nxt = index_out;
        data_nxt  = INACTIVE;
        wrap_nxt  = 1'b0;
        clr       = 1'b0;
        scan_en   = 1'b0;
        case (state_nxt)
            DIRECT: begin
                index_nxt = data_in;
                data_nxt  = decode(data_in);
            end
            SCAN: begin
                scan_en = 1'b1;
                clr     = load || (state != SCAN);
                if (load) begin
                    index_nxt = data_in;
                end else if (tick) begin
                    if (dir) begin
                        index_nxt = index_out - ONE;
                        wrap_nxt  = (index_out == FIRST);
                    end else begin
                        index_nxt = index_out + ONE;
                        wrap_nxt  = (index_out == LAST);
                    end
                end
                data_nxt = decode(index_nxt);
            end
            default: begin
                index_nxt = index_out;
                data_nxt  = INACTIVE;
            end
        endcase
    end

endmodule

// File: tb/tb_decode_scan.sv
// Directed bench for decode_scan: an active-high and an active-low instance share stimulus.
module tb_decode_scan;
    import decode_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic        load;
    logic        dir;
    logic [2:0]  data_in;
    logic [15:0] div;

    logic [7:0]  data_out;
    logic [2:0]  index_out;
    logic        wrap;
    state_t      state;

    logic [7:0]  data_out_al;
    logic [2:0]  index_out_al;
    logic        wrap_al;
    state_t      state_al;

    int n_cmp;
    int n_err;
    logic [7:0] exp_q[$];

    decode_scan #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .dir       (dir),
        .data_in   (data_in),
        .div       (div),
        .data_out  (data_out),
        .index_out (index_out),
        .wrap      (wrap),
        .state     (state)
    );

    decode_scan #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1)) dut_al (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .dir       (dir),
        .data_in   (data_in),
        .div       (div),
        .data_out  (data_out_al),
        .index_out (index_out_al),
        .wrap      (wrap_al),
        .state     (state_al)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [7:0] e;
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        en      = 1'b0;
        mode    = MODE_DIRECT;
        load    = 1'b0;
        dir     = 1'b0;
        data_in = 3'd0;
        div     = 16'd0;

        steps(2);
        check("rst_index", 32'(index_out), 32'd0);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_data_al", 32'(data_out_al), 32'hFF);

        rst = 1'b0;
        step();
        check("idle_data", 32'(data_out), 32'h00);
        check("idle_wrap", 32'(wrap), 32'd0);

        // DIRECT sweep through the scoreboard queue
        en   = 1'b1;
        mode = MODE_DIRECT;
        for (int i = 0; i < 8; i++) begin
            data_in = 3'(i);
            exp_q.push_back(8'h01 << i);
            step();
            e = exp_q.pop_front();
            check("direct_data", 32'(data_out), 32'(e));
            check("direct_index", 32'(index_out), 32'(i));
            check("direct_wrap", 32'(wrap), 32'd0);
            if (i == 3) check("al_direct_3", 32'(data_out_al), 32'hF7);
        end
        check("direct_state", 32'(state), 32'(DIRECT));

        en = 1'b0;
        step();
        check("al_idle", 32'(data_out_al), 32'hFF);
        check("idle_data2", 32'(data_out), 32'h00);
        check("idle_hold", 32'(index_out), 32'd7);

        // load outside SCAN is ignored
        load    = 1'b1;
        data_in = 3'd2;
        step();
        check("load_idle_ign", 32'(index_out), 32'd7);

        // SCAN up, div=2, from 6
        en      = 1'b1;
        mode    = MODE_SCAN;
        dir     = 1'b0;
        div     = 16'd2;
        data_in = 3'd6;
        step();
        load = 1'b0;
        check("scan_load6", 32'(index_out), 32'd6);
        check("scan_load_wrap", 32'(wrap), 32'd0);
        check("scan_data6", 32'(data_out), 32'h40);
        check("scan_state", 32'(state), 32'(SCAN));
        steps(2);
        check("scan_hold6", 32'(index_out), 32'd6);
        step();
        check("scan_step7", 32'(index_out), 32'd7);
        check("scan_nowrap7", 32'(wrap), 32'd0);
        steps(2);
        check("scan_hold7", 32'(index_out), 32'd7);
        step();
        check("scan_wrap0", 32'(index_out), 32'd0);
        check("scan_wrap_pulse", 32'(wrap), 32'd1);
        check("scan_data0", 32'(data_out), 32'h01);
        step();
        check("scan_wrap_clear", 32'(wrap), 32'd0);

        // pause mid-scan, then resume with prescaler restarted
        en = 1'b0;
        step();
        check("pause_data", 32'(data_out), 32'h00);
        steps(9);
        check("pause_data10", 32'(data_out), 32'h00);
        check("pause_index", 32'(index_out), 32'd0);
        en = 1'b1;
        step();
        check("resume_index", 32'(index_out), 32'd0);
        check("resume_data", 32'(data_out), 32'h01);
        steps(2);
        check("resume_hold", 32'(index_out), 32'd0);
        step();
        check("resume_step", 32'(index_out), 32'd1);

        // lower div below the running prescaler count
        step();
        check("div_pre", 32'(index_out), 32'd1);
        div = 16'd0;
        step();
        check("div_lower", 32'(index_out), 32'd2);
        step();
        check("div_zero", 32'(index_out), 32'd3);

        // SCAN down, div=0, load 1
        dir     = 1'b1;
        load    = 1'b1;
        data_in = 3'd1;
        step();
        load = 1'b0;
        check("down_load1", 32'(index_out), 32'd1);
        check("down_load_wrap", 32'(wrap), 32'd0);
        step();
        check("down_0", 32'(index_out), 32'd0);
        check("down_0_wrap", 32'(wrap), 32'd0);
        step();
        check("down_7", 32'(index_out), 32'd7);
        check("down_7_wrap", 32'(wrap), 32'd1);
        check("down_7_data", 32'(data_out), 32'h80);

        // load coincident with a step: loaded value wins
        load    = 1'b1;
        data_in = 3'd4;
        step();
        load = 1'b0;
        check("load_prio", 32'(index_out), 32'd4);
        step();
        check("after_load", 32'(index_out), 32'd3);

        // dir change does not restart the prescaler
        div = 16'd2;
        step();
        check("dir_pre1", 32'(index_out), 32'd3);
        dir = 1'b0;
        step();
        check("dir_pre2", 32'(index_out), 32'd3);
        step();
        check("dir_up", 32'(index_out), 32'd4);

        // reset mid-SCAN at index 5
        load    = 1'b1;
        data_in = 3'd5;
        step();
        load = 1'b0;
        check("pre_rst5", 32'(index_out), 32'd5);
        rst = 1'b1;
        step();
        check("mid_rst_index", 32'(index_out), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'h00);
        check("mid_rst_wrap", 32'(wrap), 32'd0);
        check("mid_rst_state", 32'(state), 32'(IDLE));

        // first cycle after release enters SCAN without stepping
        rst = 1'b0;
        div = 16'd0;
        step();
        check("rel_index", 32'(index_out), 32'd0);
        check("rel_wrap", 32'(wrap), 32'd0);
        check("rel_state", 32'(state), 32'(SCAN));
        step();
        check("rel_step", 32'(index_out), 32'd1);
        check("al_scan_1", 32'(data_out_al), 32'hFD);
        check("al_index", 32'(index_out_al), 32'd1);
        check("al_wrap", 32'(wrap_al), 32'd0);
        check("al_state", 32'(state_al), 32'(SCAN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_scan.md
DECODE_SCAN -- requirements
Module: decode_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, meaning select width; output width OUT_W = 2**SEL_W is derived, not overridable.
REQ-002 The block SHALL have parameter DIV_W, default 16, meaning scan prescaler width.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0, meaning 1 inverts every data_out bit.
REQ-004 Port clk  in  1  sole clock; all logic on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port en  in  1  enable; 0 forces outputs inactive and freezes state.
REQ-007 Port mode  in  1  0 = DIRECT decode, 1 = SCAN (walking one).
REQ-008 Port load  in  1  one-cycle pulse; in SCAN, index <= data_in.
REQ-009 Port dir  in  1  SCAN direction, 0 = up, 1 = down.
REQ-010 Port data_in  in  SEL_W  select value.
REQ-011 Port div  in  DIV_W  SCAN step period minus one, in clk cycles.
REQ-012 Port data_out  out  OUT_W  registered one-hot of index (polarity per ACTIVE_LOW).
REQ-013 Port index_out  out  SEL_W  registered current index.
REQ-014 Port wrap  out  1  one-cycle pulse on index wrap-around in SCAN.

Function
REQ-015 States SHALL be IDLE (en=0), DIRECT (en=1, mode=0), SCAN (en=1, mode=1); next state is re-evaluated every cycle from en and mode.
REQ-016 In IDLE, index and prescaler SHALL hold; data_out SHALL be all-inactive (0s, or 1s if ACTIVE_LOW); wrap SHALL be 0.
REQ-017 In DIRECT, index SHALL load data_in every cycle; data_out and index_out SHALL reflect data_in with exactly 1 cycle latency.
REQ-018 Active data_out SHALL have exactly one active bit, at position index (bit 0 = index 0).
REQ-019 In SCAN, prescaler SHALL count 0..div; on cycle where prescaler >= div, prescaler <= 0 and index steps +1 (dir=0) or -1 (dir=1), modulo OUT_W.
REQ-020 div=0 SHALL step index every cycle; div lowered below current prescaler SHALL step on the next cycle (>= compare).
REQ-021 wrap SHALL pulse for the cycle index_out changes OUT_W-1 -> 0 (up) or 0 -> OUT_W-1 (down); never in DIRECT or on load.
REQ-022 load in SCAN SHALL set index <= data_in, prescaler <= 0, and take priority over a coincident step; load outside SCAN SHALL be ignored.
REQ-023 Any transition into SCAN SHALL clear prescaler to 0; index SHALL be retained.
REQ-024 dir changes SHALL take effect at the next step without resetting prescaler.
REQ-025 Leaving SCAN for IDLE and returning SHALL resume from held index with prescaler cleared.

Reset
REQ-026 With rst=1 at a clock edge, state <= IDLE, index <= 0, prescaler <= 0, index_out <= 0, wrap <= 0, data_out <= all-inactive.
REQ-027 rst SHALL take priority over en, mode, load and any in-progress count.
REQ-028 First cycle after rst release SHALL behave per en/mode with no residual wrap.

Structure
REQ-029 A shared package decode_pkg SHALL hold the state enum (IDLE, DIRECT, SCAN) and mode constants MODE_DIRECT=0, MODE_SCAN=1.
REQ-030 The prescaler SHALL be a sub-module tick_div (clk, rst, clr, en, div -> tick).
REQ-031 All outputs SHALL be driven directly from registers.

Verification (SEL_W=3, DIV_W=16, ACTIVE_LOW=0 unless noted)
REQ-032 DIRECT: en=1, data_in sweeps 0..7 one per cycle -> data_out 0x01..0x80 each one cycle later, index_out matches, wrap=0.
REQ-033 SCAN up, div=2: from index 6 -> index 7 after 3 cycles, then 0 after 3 more with wrap=1 for that single cycle.
REQ-034 SCAN down, div=0, load data_in=1 -> index 1,0,7 on successive cycles, wrap=1 with the 0->7 step; load coincident with step -> loaded value wins.
REQ-035 en=0 mid-scan for 10 cycles -> data_out=0x00, index frozen; en=1 -> same index, next step div+1 cycles later.
REQ-036 ACTIVE_LOW=1, DIRECT, data_in=3 -> data_out=0xF7; en=0 -> 0xFF.
REQ-037 rst asserted mid-SCAN at index 5 -> next cycle index_out=0, data_out=0x00, wrap=0, state IDLE.
